conv_mac_engine: RTL and testbench

- Convolution MAC stage directly downstream of the per-filter weight ROM.
- Latches one filter's packed multi-channel weights when the ROM raises weight_valid.
- Accepts packed K×K×C input windows over a valid/ready handshake.
- Computes one signed dot product per window, one input channel per cycle, and presents the result over a valid/ready handshake.

---
 rtl/conv_mac_engine.sv | 147 ++++++++++++++
 tb/tb_conv_mac_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// Convolution MAC stage: latches a filter's weights, accepts a K*K*C window and
// accumulates one channel per cycle. Optional ReLU output stage: CONV_MAC_RELU_EN.
module conv_mac_engine #(
  parameter int INPUT_CHANNELS = 3,
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int OUT_WIDTH      = 32
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] weight_in,
  input  logic                                                  weight_valid,
  output logic                                                  weights_loaded,
  input  logic [INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   window_in,
  input  logic                                                  window_valid,
  output logic                                                  window_ready,
  output logic [OUT_WIDTH-1:0]                                  result_out,
  output logic                                                  result_valid,
  input  logic                                                  result_ready
);

  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NELEM  = INPUT_CHANNELS * KK;
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int CH_W   = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
  localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(INPUT_CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                            state_r;
  logic [NELEM*WEIGHT_WIDTH-1:0]     weight_r;
  logic [NELEM*DATA_WIDTH-1:0]       window_r;
  logic [OUT_WIDTH-1:0]              acc_r;
  logic [CH_W-1:0]                   ch_r;
  logic                              weights_loaded_r;
  logic                              window_ready_r;
  logic [OUT_WIDTH-1:0]              result_out_r;
  logic                              result_valid_r;

  logic signed [DATA_WIDTH-1:0]      pix_s;
  logic signed [WEIGHT_WIDTH-1:0]    wgt_s;
  logic signed [PROD_W-1:0]          prod_s;
  logic [OUT_WIDTH-1:0]              chan_sum_s;
  logic [OUT_WIDTH-1:0]              acc_next_s;
  logic [OUT_WIDTH-1:0]              result_s;

  // Per-channel dot product of the current channel, sign-extended into the accumulator width
  always_comb begin
    pix_s      = {DATA_WIDTH{1'b0}};
    wgt_s      = {WEIGHT_WIDTH{1'b0}};
    prod_s     = {PROD_W{1'b0}};
    chan_sum_s = {OUT_WIDTH{1'b0}};
    for (int j = 0; j < KK; j++) begin
      pix_s      = $signed(window_r[(int'(ch_r) * KK + j) * DATA_WIDTH +: DATA_WIDTH]);
      wgt_s      = $signed(weight_r[(int'(ch_r) * KK + j) * WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      prod_s     = PROD_W'(pix_s) * PROD_W'(wgt_s);
      chan_sum_s = chan_sum_s + {{(OUT_WIDTH - PROD_W){prod_s[PROD_W-1]}}, prod_s};
    end
  end

  // Running sum plus the optional ReLU applied only to the final value
  always_comb begin
    acc_next_s = acc_r + chan_sum_s;
`ifdef CONV_MAC_RELU_EN
    if (acc_next_s[OUT_WIDTH-1]) begin
      result_s = {OUT_WIDTH{1'b0}};
    end else begin
      result_s = acc_next_s;
    end
`else
    result_s = acc_next_s;
`endif
  end

  // Control FSM with all datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      weight_r         <= {(NELEM*WEIGHT_WIDTH){1'b0}};
      window_r         <= {(NELEM*DATA_WIDTH){1'b0}};
      acc_r            <= {OUT_WIDTH{1'b0}};
      ch_r             <= {CH_W{1'b0}};
      weights_loaded_r <= 1'b0;
      window_ready_r   <= 1'b0;
      result_out_r     <= {OUT_WIDTH{1'b0}};
      result_valid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (weight_valid) begin
            weight_r         <= weight_in;
            weights_loaded_r <= 1'b1;
            window_ready_r   <= 1'b1;
            state_r          <= READY;
          end
        end
        READY: begin
          if (weight_valid) begin
            weight_r <= weight_in;
          end
          // window_ready_r is already high here, so window_valid completes the handshake
          if (window_valid) begin
            window_r       <= window_in;
            acc_r          <= {OUT_WIDTH{1'b0}};
            ch_r           <= {CH_W{1'b0}};
            window_ready_r <= 1'b0;
            state_r        <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc_r <= acc_next_s;
          ch_r  <= ch_r + CH_ONE;
          if (ch_r == CH_LAST) begin
            result_out_r   <= result_s;
            result_valid_r <= 1'b1;
            state_r        <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid_r <= 1'b0;
            window_ready_r <= 1'b1;
            state_r        <= READY;
          end
        end
        default: begin
          state_r        <= IDLE;
          window_ready_r <= 1'b0;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign weights_loaded = weights_loaded_r;
  assign window_ready   = window_ready_r;
  assign result_out     = result_out_r;
  assign result_valid   = result_valid_r;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed plus randomized bench for conv_mac_engine; expected sums come from a
// flat dot-product model over integer arrays.
module tb_conv_mac_engine;

  localparam int C  = 3;
  localparam int K  = 3;
  localparam int N  = C * K * K;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int OW = 32;

  logic              clk;
  logic              rst_n;
  logic [N*WW-1:0]   weight_in;
  logic              weight_valid;
  logic              weights_loaded;
  logic [N*DW-1:0]   window_in;
  logic              window_valid;
  logic              window_ready;
  logic [OW-1:0]     result_out;
  logic              result_valid;
  logic              result_ready;

  int total = 0;
  int bad   = 0;
  int w_arr [N];
  int p_arr [N];

  conv_mac_engine #(
    .INPUT_CHANNELS(C), .KERNEL_SIZE(K), .DATA_WIDTH(DW),
    .WEIGHT_WIDTH(WW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .weight_in(weight_in), .weight_valid(weight_valid), .weights_loaded(weights_loaded),
    .window_in(window_in), .window_valid(window_valid), .window_ready(window_ready),
    .result_out(result_out), .result_valid(result_valid), .result_ready(result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*8-1:0] pack8(input int a [N]);
    logic [N*8-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = a[i][7:0];
    return v;
  endfunction

  // Plain signed dot product of the whole window against the filter.
  function automatic logic [31:0] model();
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(p_arr[i]) * longint'(w_arr[i]);
`ifdef CONV_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[31:0];
  endfunction

  task automatic fill_w(input int v);
    for (int i = 0; i < N; i++) w_arr[i] = v;
  endtask

  task automatic fill_p(input int v);
    for (int i = 0; i < N; i++) p_arr[i] = v;
  endtask

  task automatic rand_arrays();
    for (int i = 0; i < N; i++) begin
      w_arr[i] = int'($urandom_range(0, 255)) - 128;
      p_arr[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic load_w();
    weight_in    = pack8(w_arr);
    weight_valid = 1'b1;
    @(posedge clk); #1;
    weight_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_window(input string tag, input logic [31:0] exp,
                           input bit mid_reload, input logic [N*WW-1:0] w_mid);
    int n;
    window_in    = pack8(p_arr);
    window_valid = 1'b1;
    n = 0;
    while (window_ready !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_rdy"}, 32'(window_ready), 32'd1);
    tick();
    window_valid = 1'b0;
    weight_valid = 1'b0;
    check({tag, "_busy"}, 32'({window_ready, result_valid}), 32'd0);
    if (mid_reload) begin
      weight_in    = w_mid;
      weight_valid = 1'b1;
    end
    n = 0;
    while (result_valid !== 1'b1 && n < 20) begin tick(); n++; end
    weight_valid = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(C));
    check({tag, "_val"}, result_out, exp);
  endtask

  task automatic hold_release(input string tag, input int hold, input logic [31:0] exp);
    result_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_stable"}, result_out, exp);
      check({tag, "_hs"}, 32'({result_valid, window_ready}), 32'd2);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_rel"}, 32'({result_valid, window_ready}), 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] exp;
    rst_n        = 1'b0;
    weight_in    = '0;
    weight_valid = 1'b0;
    window_in    = '0;
    window_valid = 1'b0;
    result_ready = 1'b0;
    #12;
    check("rst_wl", 32'(weights_loaded), 32'd0);
    check("rst_wr", 32'(window_ready), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_ro", result_out, 32'd0);
    tick();
    rst_n = 1'b1;

    // Windows offered before any weights must be refused
    fill_p(1);
    window_in    = pack8(p_arr);
    window_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (window_ready || result_valid) n++;
    end
    check("no_weights", 32'(n), 32'd0);

    fill_w(1);
    load_w();
    check("load_wl", 32'(weights_loaded), 32'd1);
    check("load_wr", 32'(window_ready), 32'd1);
    do_window("ones", 32'h0000001B, 1'b0, '0);
    hold_release("ones", 5, 32'h0000001B);

    // New weights and window captured on the same edge
    fill_w(-1);
    fill_p(2);
    weight_in    = pack8(w_arr);
    weight_valid = 1'b1;
`ifdef CONV_MAC_RELU_EN
    exp = 32'h00000000;
`else
    exp = 32'hFFFFFFCA;
`endif
    do_window("neg", exp, 1'b0, '0);
    hold_release("neg", 0, exp);

    // Reload during COMPUTE is ignored; a reload in READY takes effect
    fill_w(1);
    load_w();
    fill_p(1);
    fill_w(2);
    do_window("midld", 32'd27, 1'b1, pack8(w_arr));
    hold_release("midld", 1, 32'd27);
    load_w();
    do_window("reld", 32'd54, 1'b0, '0);
    hold_release("reld", 0, 32'd54);
    check("wl_sticky", 32'(weights_loaded), 32'd1);

    for (int it = 0; it < 8; it++) begin
      rand_arrays();
      if (it % 2 == 0) begin
        load_w();
      end else begin
        weight_in    = pack8(w_arr);
        weight_valid = 1'b1;
      end
      exp = model();
      do_window("rnd", exp, 1'b0, '0);
      hold_release("rnd", int'($urandom_range(0, 3)), exp);
    end

    // Reset while a result is waiting drops it asynchronously
    rand_arrays();
    load_w();
    do_window("pre_rst", model(), 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_rv", 32'(result_valid), 32'd0);
    check("rst_done_wl", 32'(weights_loaded), 32'd0);
    check("rst_done_ro", result_out, 32'd0);
    tick();
    rst_n = 1'b1;

    // Reset in the middle of COMPUTE
    fill_w(1);
    load_w();
    fill_p(1);
    window_in    = pack8(p_arr);
    window_valid = 1'b1;
    tick();
    window_valid = 1'b0;
    tick();
    check("mid_busy", 32'(window_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_cmp_rv", 32'(result_valid), 32'd0);
    check("rst_cmp_wl", 32'(weights_loaded), 32'd0);
    tick();
    rst_n = 1'b1;
    window_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (window_ready || result_valid) n++;
    end
    check("post_rst_refuse", 32'(n), 32'd0);
    rand_arrays();
    load_w();
    check("post_rst_wr", 32'(window_ready), 32'd1);
    exp = model();
    do_window("post_rst", exp, 1'b0, '0);
    hold_release("post_rst", 2, exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
